// File: rtl/demux_4_32_buf.sv
// demux_4_32_buf: registered 1-to-4 demultiplexer with a 1-entry holding buffer per lane.
//
// A single producer presents in_data with a 2-bit destination in_addr. Accepted words land
// in the addressed lane buffer on the next rising edge. Each lane has its own valid/ready
// handshake, so a stalled lane never blocks traffic to the other lanes. Each lane also keeps
// a wrapping count of delivered words.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of all lane buffers (counters are kept)
//   in_valid/in_ready     producer handshake; in_ready is combinational
//   in_addr, in_data      destination lane (00->1 .. 11->4) and payload
//   outN_valid/outN_ready lane N handshake (valid registered)
//   outN_data             lane N buffer contents (registered)
//   cntN                  words delivered on lane N, wraps modulo 2^CNT_W
module demux_4_32_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_addr,
  input  logic [WIDTH-1:0] in_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt1,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic [CNT_W-1:0] cnt2,
  output logic             out3_valid,
  input  logic             out3_ready,
  output logic [WIDTH-1:0] out3_data,
  output logic [CNT_W-1:0] cnt3,
  output logic             out4_valid,
  input  logic             out4_ready,
  output logic [WIDTH-1:0] out4_data,
  output logic [CNT_W-1:0] cnt4
);

  typedef enum logic {StEmpty, StFull} lane_st_e;

  lane_st_e         st_q   [4];
  lane_st_e         st_d   [4];
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];

  logic [3:0] lane_ready;
  logic [3:0] lane_valid;
  logic       accept;

  assign lane_ready = {out4_ready, out3_ready, out2_ready, out1_ready};

  always_comb begin
    lane_valid = '0;
    for (int n = 0; n < 4; n++) begin
      lane_valid[n] = (st_q[n] == StFull);
    end
  end

  // Only the addressed lane gates the producer; a full lane that is draining this cycle can
  // take a new word, giving 1 word/cycle pass-through.
  assign in_ready = rst_n & ~flush & (~lane_valid[in_addr] | lane_ready[in_addr]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      st_d[n]   = st_q[n];
      data_d[n] = data_q[n];
      cnt_d[n]  = cnt_q[n];

      // A handshake in the flush cycle still completes and is counted.
      if (lane_valid[n] && lane_ready[n]) begin
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
      end

      // accept is already 0 during flush, so flush wins over any new word.
      if (flush) begin
        st_d[n] = StEmpty;
      end else if (accept && (in_addr == 2'(n))) begin
        st_d[n]   = StFull;
        data_d[n] = in_data;
      end else if (lane_valid[n] && lane_ready[n]) begin
        st_d[n] = StEmpty;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        st_q[n]   <= StEmpty;
        data_q[n] <= '0;
        cnt_q[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        st_q[n]   <= st_d[n];
        data_q[n] <= data_d[n];
        cnt_q[n]  <= cnt_d[n];
      end
    end
  end

  assign out1_valid = lane_valid[0];
  assign out2_valid = lane_valid[1];
  assign out3_valid = lane_valid[2];
  assign out4_valid = lane_valid[3];

  assign out1_data = data_q[0];
  assign out2_data = data_q[1];
  assign out3_data = data_q[2];
  assign out4_data = data_q[3];

  assign cnt1 = cnt_q[0];
  assign cnt2 = cnt_q[1];
  assign cnt3 = cnt_q[2];
  assign cnt4 = cnt_q[3];

endmodule
